// File: rtl/rv32_timer_pkg.sv
// Shared constants and helpers for the RV32 machine timer: register offsets,
// CTRL field layout and the byte-enable merge used by every writable register.
package rv32_timer_pkg;

   localparam logic [2:0] RV32_TIMER_MTIME_LO    = 3'd0;
   localparam logic [2:0] RV32_TIMER_MTIME_HI    = 3'd1;
   localparam logic [2:0] RV32_TIMER_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] RV32_TIMER_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] RV32_TIMER_CYCLE_LO    = 3'd4;
   localparam logic [2:0] RV32_TIMER_CYCLE_HI    = 3'd5;
   localparam logic [2:0] RV32_TIMER_CTRL        = 3'd6;
   localparam logic [2:0] RV32_TIMER_RESERVED    = 3'd7;

   localparam int RV32_TIMER_CTRL_ENABLE_BIT = 31;
   localparam int RV32_TIMER_CTRL_DIV_MSB    = 15;
   localparam int RV32_TIMER_CTRL_DIV_LSB    = 0;

   typedef struct packed {
      logic        enable;
      logic [15:0] div;
   } rv32_timer_ctrl_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  mask);
      logic [31:0] merged;
      merged = old_value;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            merged[8*i +: 8] = new_value[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_value[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/rv32_timer_if.sv
// Data-memory bus slice seen by the machine timer: one request per cycle,
// single-cycle acknowledge, no back-pressure.
interface rv32_timer_if;
   logic        sel_in;
   logic        read_in;
   logic        write_in;
   logic [2:0]  address_in;
   logic [3:0]  write_mask_in;
   logic [31:0] write_value_in;
   logic [31:0] read_value_out;
   logic        ready_out;

   modport master (
      output sel_in, read_in, write_in, address_in, write_mask_in, write_value_in,
      input  read_value_out, ready_out
   );

   modport slave (
      input  sel_in, read_in, write_in, address_in, write_mask_in, write_value_in,
      output read_value_out, ready_out
   );
endinterface

// File: rtl/rv32_timer_prescaler.sv
// Timer prescaler: holds CTRL (enable, div) and the divide counter; raises
// tick on the cycle mtime should advance.
module rv32_timer_prescaler
   import rv32_timer_pkg::*;
#(
   parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ctrl_write,
   input  logic [31:0] write_value,
   input  logic [3:0]  write_mask,
   output logic [31:0] ctrl_word,
   output logic        tick
);

   rv32_timer_ctrl_t ctrl_r;
   logic [15:0]      count_r;
   logic [31:0]      ctrl_new_s;
   logic             unused_ctrl_bits_s;

   // Assemble the architectural CTRL word and its byte-merged next value.
   always_comb begin
      ctrl_word = 32'd0;
      ctrl_word[RV32_TIMER_CTRL_ENABLE_BIT] = ctrl_r.enable;
      ctrl_word[RV32_TIMER_CTRL_DIV_MSB:RV32_TIMER_CTRL_DIV_LSB] = ctrl_r.div;
      ctrl_new_s = merge_bytes(ctrl_word, write_value, write_mask);
   end

   assign unused_ctrl_bits_s = ^ctrl_new_s[30:16];
   assign tick = ctrl_r.enable && (count_r == ctrl_r.div);

   // CTRL register and divide counter; a CTRL write restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_r.enable <= 1'b1;
         ctrl_r.div    <= PRESCALE_RESET;
         count_r       <= 16'd0;
      end else if (ctrl_write) begin
         ctrl_r.enable <= ctrl_new_s[RV32_TIMER_CTRL_ENABLE_BIT];
         ctrl_r.div    <= ctrl_new_s[RV32_TIMER_CTRL_DIV_MSB:RV32_TIMER_CTRL_DIV_LSB];
         count_r       <= 16'd0;
      end else if (ctrl_r.enable) begin
         count_r <= tick ? 16'd0 : count_r + 16'd1;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/rv32_timer.sv
// RISC-V machine timer on the data-memory bus: prescaled 64-bit mtime,
// mtimecmp, tear-free window onto the core cycle counter, registered MTIP.
module rv32_timer
   import rv32_timer_pkg::*;
#(
   parameter logic [15:0] PRESCALE_RESET = 16'd0,
   parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic         clk,
   input  logic         reset,
   rv32_timer_if.slave  bus,
   input  logic [63:0]  cycle_in,
   output logic         timer_interrupt_out
);

   logic [63:0] mtime_r;
   logic [63:0] mtimecmp_r;
   logic [31:0] mtime_hi_latch_r;
   logic [31:0] cycle_hi_latch_r;
   logic [31:0] read_value_r;
   logic        ready_r;
   logic        irq_r;

   logic        req_s;
   logic        rd_s;
   logic        wr_s;
   logic        tick_s;
   logic [31:0] ctrl_word_s;
   logic [31:0] read_mux_s;
   logic [31:0] wr_merge_s;

   assign req_s = bus.sel_in && (bus.read_in || bus.write_in);
   assign rd_s  = bus.sel_in && bus.read_in;
   assign wr_s  = bus.sel_in && bus.write_in;

   rv32_timer_prescaler #(
      .PRESCALE_RESET (PRESCALE_RESET)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .ctrl_write  (wr_s && (bus.address_in == RV32_TIMER_CTRL)),
      .write_value (bus.write_value_in),
      .write_mask  (bus.write_mask_in),
      .ctrl_word   (ctrl_word_s),
      .tick        (tick_s)
   );

   // Read data from pre-write state; HI halves come from the snapshot latches.
   always_comb begin
      read_mux_s = 32'd0;
      wr_merge_s = 32'd0;
      case (bus.address_in)
         RV32_TIMER_MTIME_LO: begin
            read_mux_s = mtime_r[31:0];
            wr_merge_s = merge_bytes(mtime_r[31:0], bus.write_value_in, bus.write_mask_in);
         end
         RV32_TIMER_MTIME_HI: begin
            read_mux_s = mtime_hi_latch_r;
            wr_merge_s = merge_bytes(mtime_r[63:32], bus.write_value_in, bus.write_mask_in);
         end
         RV32_TIMER_MTIMECMP_LO: begin
            read_mux_s = mtimecmp_r[31:0];
            wr_merge_s = merge_bytes(mtimecmp_r[31:0], bus.write_value_in, bus.write_mask_in);
         end
         RV32_TIMER_MTIMECMP_HI: begin
            read_mux_s = mtimecmp_r[63:32];
            wr_merge_s = merge_bytes(mtimecmp_r[63:32], bus.write_value_in, bus.write_mask_in);
         end
         RV32_TIMER_CYCLE_LO:  read_mux_s = cycle_in[31:0];
         RV32_TIMER_CYCLE_HI:  read_mux_s = cycle_hi_latch_r;
         RV32_TIMER_CTRL:      read_mux_s = ctrl_word_s;
         RV32_TIMER_RESERVED:  read_mux_s = 32'd0;
         default:              read_mux_s = 32'd0;
      endcase
   end

   // Bus response, snapshot latches, counter/compare state and MTIP.
   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_r          <= 64'd0;
         mtimecmp_r       <= MTIMECMP_RESET;
         mtime_hi_latch_r <= 32'd0;
         cycle_hi_latch_r <= 32'd0;
         read_value_r     <= 32'd0;
         ready_r          <= 1'b0;
         irq_r            <= 1'b0;
      end else begin
         ready_r <= req_s;
         irq_r   <= (mtime_r >= mtimecmp_r);

         if (rd_s) begin
            read_value_r <= read_mux_s;
         end else begin
            read_value_r <= read_value_r;
         end

         if (rd_s && (bus.address_in == RV32_TIMER_MTIME_LO)) begin
            mtime_hi_latch_r <= mtime_r[63:32];
         end else begin
            mtime_hi_latch_r <= mtime_hi_latch_r;
         end

         if (rd_s && (bus.address_in == RV32_TIMER_CYCLE_LO)) begin
            cycle_hi_latch_r <= cycle_in[63:32];
         end else begin
            cycle_hi_latch_r <= cycle_hi_latch_r;
         end

         // A bus write to either mtime half wins over the tick for the whole word.
         if (wr_s && (bus.address_in == RV32_TIMER_MTIME_LO)) begin
            mtime_r[31:0] <= wr_merge_s;
         end else if (wr_s && (bus.address_in == RV32_TIMER_MTIME_HI)) begin
            mtime_r[63:32] <= wr_merge_s;
         end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
         end else begin
            mtime_r <= mtime_r;
         end

         if (wr_s && (bus.address_in == RV32_TIMER_MTIMECMP_LO)) begin
            mtimecmp_r[31:0] <= wr_merge_s;
         end else if (wr_s && (bus.address_in == RV32_TIMER_MTIMECMP_HI)) begin
            mtimecmp_r[63:32] <= wr_merge_s;
         end else begin
            mtimecmp_r <= mtimecmp_r;
         end
      end
   end

   assign bus.read_value_out  = read_value_r;
   assign bus.ready_out       = ready_r;
   assign timer_interrupt_out = irq_r;

endmodule

// File: tb/tb_rv32_timer.sv
// Directed bench for rv32_timer: a cycle-level behavioural model checked on
// every cycle, plus hand-computed read values for the key scenarios.
module tb_rv32_timer;

   logic        clk;
   logic        reset;
   logic [63:0] cycle_in;
   logic        timer_interrupt_out;

   rv32_timer_if bus_if ();

   rv32_timer dut (
      .clk                 (clk),
      .reset               (reset),
      .bus                 (bus_if),
      .cycle_in            (cycle_in),
      .timer_interrupt_out (timer_interrupt_out)
   );

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] m_mtime, m_cmp;
   logic        m_en;
   logic [15:0] m_div, m_cnt;
   logic [31:0] m_mlatch, m_clatch, m_rdata;
   logic        m_ready, m_irq, m_valid = 1'b0;

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
      logic [31:0] keep;
      keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      return (o & ~keep) | (n & keep);
   endfunction

   function automatic logic [31:0] m_ctrl_word();
      return {m_en, 15'd0, m_div};
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_mtime[31:0];
         3'd1:    return m_mlatch;
         3'd2:    return m_cmp[31:0];
         3'd3:    return m_cmp[63:32];
         3'd4:    return cycle_in[31:0];
         3'd5:    return m_clatch;
         3'd6:    return m_ctrl_word();
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic bit31(input logic [31:0] w);
      return w[31];
   endfunction

   function automatic logic [15:0] low16(input logic [31:0] w);
      return w[15:0];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_mtime <= 64'd0; m_cmp <= 64'hFFFF_FFFF_FFFF_FFFF;
         m_en <= 1'b1; m_div <= 16'd0; m_cnt <= 16'd0;
         m_mlatch <= 32'd0; m_clatch <= 32'd0; m_rdata <= 32'd0;
         m_ready <= 1'b0; m_irq <= 1'b0; m_valid <= 1'b1;
      end else begin
         m_ready <= bus_if.sel_in && (bus_if.read_in || bus_if.write_in);
         m_irq   <= (m_mtime >= m_cmp);
         if (bus_if.sel_in && bus_if.read_in) begin
            m_rdata <= m_read(bus_if.address_in);
            if (bus_if.address_in == 3'd0) m_mlatch <= m_mtime[63:32];
            if (bus_if.address_in == 3'd4) m_clatch <= cycle_in[63:32];
         end
         if (bus_if.sel_in && bus_if.write_in && bus_if.address_in == 3'd6) begin
            m_en  <= bit31(bmerge(m_ctrl_word(), bus_if.write_value_in, bus_if.write_mask_in));
            m_div <= low16(bmerge(m_ctrl_word(), bus_if.write_value_in, bus_if.write_mask_in));
            m_cnt <= 16'd0;
         end else if (m_en) begin
            m_cnt <= (m_cnt == m_div) ? 16'd0 : m_cnt + 16'd1;
         end
         if (bus_if.sel_in && bus_if.write_in && bus_if.address_in == 3'd0)
            m_mtime <= {m_mtime[63:32], bmerge(m_mtime[31:0], bus_if.write_value_in, bus_if.write_mask_in)};
         else if (bus_if.sel_in && bus_if.write_in && bus_if.address_in == 3'd1)
            m_mtime <= {bmerge(m_mtime[63:32], bus_if.write_value_in, bus_if.write_mask_in), m_mtime[31:0]};
         else if (m_en && m_cnt == m_div)
            m_mtime <= m_mtime + 64'd1;
         if (bus_if.sel_in && bus_if.write_in && bus_if.address_in == 3'd2)
            m_cmp <= {m_cmp[63:32], bmerge(m_cmp[31:0], bus_if.write_value_in, bus_if.write_mask_in)};
         else if (bus_if.sel_in && bus_if.write_in && bus_if.address_in == 3'd3)
            m_cmp <= {bmerge(m_cmp[63:32], bus_if.write_value_in, bus_if.write_mask_in), m_cmp[31:0]};
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("ready_out", {63'd0, bus_if.ready_out}, {63'd0, m_ready});
         chk("timer_interrupt_out", {63'd0, timer_interrupt_out}, {63'd0, m_irq});
         chk("read_value_out", {32'd0, bus_if.read_value_out}, {32'd0, m_rdata});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [3:0] m, input logic [31:0] d);
      bus_if.sel_in = 1'b1; bus_if.write_in = 1'b1; bus_if.read_in = 1'b0;
      bus_if.address_in = a; bus_if.write_mask_in = m; bus_if.write_value_in = d;
      cyc();
      bus_if.sel_in = 1'b0; bus_if.write_in = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus_if.sel_in = 1'b1; bus_if.read_in = 1'b1; bus_if.write_in = 1'b0;
      bus_if.address_in = a;
      cyc();
      d = bus_if.read_value_out;
      bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0;
   endtask

   task automatic bus_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
      bus_if.sel_in = 1'b1; bus_if.read_in = 1'b1; bus_if.write_in = 1'b1;
      bus_if.address_in = a; bus_if.write_mask_in = 4'hF; bus_if.write_value_in = wd;
      cyc();
      d = bus_if.read_value_out;
      bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0; bus_if.write_in = 1'b0;
   endtask

   initial begin
      logic [31:0] a, b;
      reset = 1'b1;
      cycle_in = 64'd0;
      bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0; bus_if.write_in = 1'b0;
      bus_if.address_in = 3'd0; bus_if.write_mask_in = 4'h0; bus_if.write_value_in = 32'd0;
      idle(3);
      chk("reset read_value", {32'd0, bus_if.read_value_out}, 64'd0);
      chk("reset irq", {63'd0, timer_interrupt_out}, 64'd0);
      reset = 1'b0;

      // Free-running at div=0: five idle ticks, then read 5.
      idle(5);
      bus_read(3'd0, a);
      chk("mtime after 5 idle", {32'd0, a}, 64'd5);
      chk("ready after read", {63'd0, bus_if.ready_out}, 64'd1);

      // Divide by 4: 16 cycles advance mtime by exactly 4.
      bus_write(3'd6, 4'hF, 32'h8000_0003);
      bus_read(3'd6, a);
      chk("ctrl readback", {32'd0, a}, 64'h8000_0003);
      bus_read(3'd0, a);
      idle(15);
      bus_read(3'd0, b);
      chk("div4 advance", {32'd0, b - a}, 64'd4);
      bus_write(3'd6, 4'hF, 32'h0000_0000);
      bus_read(3'd0, a);
      idle(10);
      bus_read(3'd0, b);
      chk("frozen mtime", {32'd0, b}, {32'd0, a});

      // Compare threshold 10 from mtime 0.
      bus_write(3'd1, 4'hF, 32'd0);
      bus_write(3'd0, 4'hF, 32'd0);
      bus_write(3'd3, 4'hF, 32'd0);
      bus_write(3'd2, 4'hF, 32'd10);
      bus_write(3'd6, 4'hF, 32'h8000_0000);
      idle(10);
      chk("irq before match", {63'd0, timer_interrupt_out}, 64'd0);
      idle(1);
      chk("irq at match+1", {63'd0, timer_interrupt_out}, 64'd1);
      bus_write(3'd2, 4'hF, 32'hFFFF_FFFF);
      chk("irq still high", {63'd0, timer_interrupt_out}, 64'd1);
      idle(1);
      chk("irq cleared", {63'd0, timer_interrupt_out}, 64'd0);

      // LO/HI wrap read is never torn.
      bus_write(3'd6, 4'hF, 32'd0);
      bus_write(3'd0, 4'hF, 32'hFFFF_FFFF);
      bus_write(3'd1, 4'hF, 32'd0);
      bus_write(3'd6, 4'hF, 32'h8000_0000);
      bus_read(3'd0, a);
      bus_read(3'd1, b);
      chk("wrap pair lo", {32'd0, a}, 64'hFFFF_FFFF);
      chk("wrap pair hi", {32'd0, b}, 64'd0);
      bus_read(3'd0, a);
      bus_read(3'd1, b);
      chk("post-wrap pair", {b, a}, 64'h0000_0001_0000_0001);

      // Cycle counter snapshot and read-only behaviour.
      cycle_in = 64'h0000_0001_2345_6789;
      bus_read(3'd4, a);
      cycle_in = 64'h0000_0002_0000_0000;
      bus_read(3'd5, b);
      chk("cycle lo", {32'd0, a}, 64'h2345_6789);
      chk("cycle hi latched", {32'd0, b}, 64'd1);
      bus_write(3'd4, 4'hF, 32'hDEAD_BEEF);
      bus_read(3'd4, a);
      bus_read(3'd5, b);
      chk("cycle write ignored", {b, a}, 64'h0000_0002_0000_0000);
      bus_write(3'd7, 4'hF, 32'hCAFE_F00D);
      bus_read(3'd7, a);
      chk("reserved reads 0", {32'd0, a}, 64'd0);

      // Byte-masked mtime write in a tick cycle suppresses the increment.
      bus_write(3'd6, 4'hF, 32'd0);
      bus_write(3'd1, 4'hF, 32'd0);
      bus_write(3'd0, 4'hF, 32'h1234_5678);
      bus_write(3'd6, 4'hF, 32'h8000_0000);
      bus_write(3'd0, 4'b0001, 32'hAAAA_AA55);
      bus_read(3'd0, a);
      chk("masked tick write", {32'd0, a}, 64'h1234_5655);

      // Reset during a pending read.
      bus_if.sel_in = 1'b1; bus_if.read_in = 1'b1; bus_if.address_in = 3'd2;
      cyc();
      chk("pending ack", {63'd0, bus_if.ready_out}, 64'd1);
      reset = 1'b1;
      cyc();
      chk("ack dropped by reset", {63'd0, bus_if.ready_out}, 64'd0);
      chk("read_value reset", {32'd0, bus_if.read_value_out}, 64'd0);
      bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0;
      reset = 1'b0;
      bus_read(3'd0, a);
      chk("mtime after reset", {32'd0, a}, 64'd0);
      bus_read(3'd3, a);
      chk("mtimecmp_hi after reset", {32'd0, a}, 64'hFFFF_FFFF);
      bus_read(3'd6, a);
      chk("ctrl after reset", {32'd0, a}, 64'h8000_0000);
      bus_read(3'd1, a);
      chk("mtime_hi latch after reset", {32'd0, a}, 64'd0);

      // Simultaneous read and write returns the pre-write value.
      bus_rw(3'd2, 32'h0000_0077, a);
      chk("rw pre-write value", {32'd0, a}, 64'hFFFF_FFFF);
      bus_read(3'd2, a);
      chk("rw write landed", {32'd0, a}, 64'h77);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
